// File: rtl/mult_unit.sv
// Iterative radix-2 shift-add multiplier for MULT/MULTU; WIDTH steps per operation.
// Signed operands are multiplied as magnitudes and the product is negated at write-back.
module mult_unit #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               op_signed,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               flush,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] result
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t               state_q,  state_d;
    logic [CW-1:0]        cnt_q,    cnt_d;
    logic [2*WIDTH-1:0]   mcand_q,  mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [2*WIDTH-1:0]   acc_q,    acc_d;
    logic                 neg_q,    neg_d;
    logic [2*WIDTH-1:0]   result_q, result_d;

    logic [WIDTH-1:0]     a_mag;
    logic [WIDTH-1:0]     b_mag;
    logic [2*WIDTH-1:0]   sum;
    logic                 accept;

    always_comb begin
        a_mag = (op_signed && a[WIDTH-1]) ? -a : a;
        b_mag = (op_signed && b[WIDTH-1]) ? -b : b;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        neg_d    = neg_q;
        result_d = result_q;
        sum      = acc_q + (mplier_q[0] ? mcand_q : '0);
        // flush always beats a new request
        accept   = start && !flush;

        case (state_q)
            S_RUN: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    acc_d    = sum;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        result_d = neg_q ? -sum : sum;
                        state_d  = S_DONE;
                    end
                end
            end
            default: begin
                // IDLE and DONE accept identically, so DONE can chain without a bubble
                state_d = S_IDLE;
                if (accept) begin
                    mcand_d  = {{WIDTH{1'b0}}, a_mag};
                    mplier_d = b_mag;
                    neg_d    = op_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = S_RUN;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            neg_q    <= neg_d;
            result_q <= result_d;
        end
    end

    assign busy   = (state_q == S_RUN);
    assign done   = (state_q == S_DONE);
    assign result = result_q;

endmodule

// File: tb/tb_mult_unit.sv
// Bench for mult_unit (WIDTH=32): directed vectors, expected products queued and
// matched against each done pulse by a monitor running alongside the stimulus.
module tb_mult_unit;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic           op_signed = 1'b0;
    logic [W-1:0]   a = '0;
    logic [W-1:0]   b = '0;
    logic           flush = 1'b0;
    logic           busy;
    logic           done;
    logic [2*W-1:0] result;

    int total = 0;
    int bad = 0;
    logic [2*W-1:0] exp_q[$];
    logic [2*W-1:0] last_exp = '0;

    mult_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .op_signed(op_signed),
        .a(a), .b(b), .flush(flush), .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic monitor();
        logic [2*W-1:0] e;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", {63'd0, done}, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    last_exp = e;
                    check("result", result, e);
                end
            end
        end
    endtask

    // Caller sits at a falling edge; returns at the falling edge after the accepting edge.
    task automatic issue(input logic sgn, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic [2*W-1:0] e, input logic expect_done);
        start = 1'b1; op_signed = sgn; a = av; b = bv;
        if (expect_done) exp_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy || done) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check(name, {63'd0, n < 100}, 64'd1);
    endtask

    initial begin
        fork
            monitor();
        join_none

        // reset state
        repeat (2) @(negedge clk);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_result", result, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // MULTU all-ones, with cycle-exact busy/done timing
        issue(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b1);
        check("busy_at_k", {63'd0, busy}, 64'd1);
        for (int i = 1; i < W; i++) begin
            @(negedge clk);
            check("busy_run", {63'd0, busy}, 64'd1);
        end
        @(negedge clk);
        check("busy_after_k32", {63'd0, busy}, 64'd0);
        check("done_after_k32", {63'd0, done}, 64'd1);
        @(negedge clk);
        check("done_one_cycle", {63'd0, done}, 64'd0);
        wait_idle("idle_multu");

        // signed cases and most-negative operands
        issue(1'b1, 32'hFFFF_FFFD, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1, 1'b1);
        wait_idle("idle_neg3x5");
        issue(1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1'b1);
        wait_idle("idle_minmin_s");
        issue(1'b0, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1'b1);
        wait_idle("idle_minmin_u");
        issue(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001, 1'b1);
        wait_idle("idle_m1m1");
        issue(1'b1, 32'd0, 32'h8000_0000, 64'h0, 1'b1);
        wait_idle("idle_zero");

        // back-to-back: start held in DONE
        issue(1'b1, 32'd7, 32'd6, 64'h0000_0000_0000_002A, 1'b1);
        begin
            int n;
            n = 0;
            while (!done && n < 60) begin
                @(negedge clk);
                n++;
            end
            check("b2b_first_done", {63'd0, done}, 64'd1);
        end
        issue(1'b0, 32'h8000_0000, 32'd2, 64'h0000_0001_0000_0000, 1'b1);
        check("b2b_no_bubble", {63'd0, busy}, 64'd1);
        wait_idle("idle_b2b");

        // start during RUN is ignored
        issue(1'b1, 32'd11, 32'hFFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFEA, 1'b1);
        repeat (4) @(negedge clk);
        start = 1'b1; op_signed = 1'b0; a = 32'd100; b = 32'd100;
        @(negedge clk);
        start = 1'b0;
        wait_idle("idle_ignore");
        repeat (40) @(negedge clk);

        // flush at edge k+10: no done, result retained
        issue(1'b0, 32'd3, 32'd4, 64'h0, 1'b0);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy", {63'd0, busy}, 64'd0);
        check("flush_result_kept", result, 64'hFFFF_FFFF_FFFF_FFEA);
        repeat (40) @(negedge clk);

        // flush together with start in IDLE: start dropped
        start = 1'b1; flush = 1'b1; a = 32'd9; b = 32'd9;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        check("flush_beats_start", {63'd0, busy}, 64'd0);
        repeat (40) @(negedge clk);

        // async reset mid-RUN
        issue(1'b0, 32'hFFFF_FFFF, 32'd2, 64'h0, 1'b0);
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_busy", {63'd0, busy}, 64'd0);
        check("arst_done", {63'd0, done}, 64'd0);
        check("arst_result", result, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        check("post_rst_result", result, 64'd0);

        // first edge after reset release accepts start
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        issue(1'b0, 32'd2, 32'd3, 64'h0000_0000_0000_0006, 1'b1);
        check("post_rst_accept", {63'd0, busy}, 64'd1);
        wait_idle("idle_post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
